// File: rtl/game_sequencer.sv
// Breakout game-flow controller: serve/play/pause/over/won sequencing, brick mask,
// lives and a saturating 4-digit BCD score fed from a pending-points counter.
module game_sequencer #(
    parameter int unsigned NUM_BRICKS   = 6,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned BRICK_POINTS = 1,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  launch,
    input  logic                  pause,
    input  logic [NUM_BRICKS-1:0] brick_hit,
    input  logic                  ball_lost,
    output logic [2:0]            state,
    output logic                  ball_park,
    output logic                  ball_run,
    output logic [NUM_BRICKS-1:0] brick_alive,
    output logic [3:0]            lives,
    output logic [3:0]            thous,
    output logic [3:0]            huns,
    output logic [3:0]            tens,
    output logic [3:0]            ones
);
    localparam int unsigned MaxPoints = NUM_BRICKS * BRICK_POINTS;
    localparam int unsigned PendW     = $clog2(MaxPoints + 2);
    localparam int unsigned CntW      = $clog2(NUM_BRICKS + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StServe  = 3'd1,
        StPlay   = 3'd2,
        StPaused = 3'd3,
        StOver   = 3'd4,
        StWon    = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            serve_q, serve_d;
    logic [NUM_BRICKS-1:0] alive_q, alive_d;
    logic [3:0]            lives_q, lives_d;
    logic                  launch_q;
    logic [PendW-1:0]      pending_q, pending_d, pts_add;
    logic [3:0]            thous_q, huns_q, tens_q, ones_q;
    logic [3:0]            thous_d, huns_d, tens_d, ones_d;
    logic [CntW-1:0]       hit_cnt;
    logic                  launch_rise, new_game, score_max;

    assign launch_rise = launch & ~launch_q;
    assign score_max   = (thous_q == 4'd9) && (huns_q == 4'd9) &&
                         (tens_q == 4'd9) && (ones_q == 4'd9);

    // Count only hits on bricks that are still alive.
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            hit_cnt = hit_cnt + CntW'(brick_hit[i] & alive_q[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        serve_d  = serve_q;
        alive_d  = alive_q;
        lives_d  = lives_q;
        pts_add  = '0;
        new_game = 1'b0;
        case (state_q)
            StIdle: begin
                if (launch_rise) begin
                    state_d = StServe;
                    serve_d = 8'(SERVE_FRAMES);
                end
            end
            StServe: begin
                if (frame_tick && !pause) begin
                    if (serve_q == 8'd1) state_d = StPlay;
                    else                 serve_d = serve_q - 8'd1;
                end
            end
            StPlay: begin
                if (pause) begin
                    state_d = StPaused;
                end else begin
                    alive_d = alive_q & ~brick_hit;
                    pts_add = PendW'(hit_cnt) * PendW'(BRICK_POINTS);
                    // Clearing the last brick wins even if the ball is lost in the same cycle.
                    if (alive_d == '0) begin
                        state_d = StWon;
                    end else if (ball_lost) begin
                        lives_d = lives_q - 4'd1;
                        if (lives_q == 4'd1) begin
                            state_d = StOver;
                        end else begin
                            state_d = StServe;
                            serve_d = 8'(SERVE_FRAMES);
                        end
                    end
                end
            end
            StPaused: begin
                if (!pause) state_d = StPlay;
            end
            StOver, StWon: begin
                if (launch_rise) begin
                    state_d  = StIdle;
                    alive_d  = '1;
                    lives_d  = 4'(LIVES_INIT);
                    new_game = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        thous_d   = thous_q;
        huns_d    = huns_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        pending_d = pending_q;
        if (new_game) begin
            thous_d   = 4'd0;
            huns_d    = 4'd0;
            tens_d    = 4'd0;
            ones_d    = 4'd0;
            pending_d = '0;
        end else begin
            if (score_max) begin
                pending_d = '0;
            end else if (pending_q != '0) begin
                pending_d = pending_q - PendW'(1);
                if (ones_q != 4'd9) begin
                    ones_d = ones_q + 4'd1;
                end else begin
                    ones_d = 4'd0;
                    if (tens_q != 4'd9) begin
                        tens_d = tens_q + 4'd1;
                    end else begin
                        tens_d = 4'd0;
                        if (huns_q != 4'd9) begin
                            huns_d = huns_q + 4'd1;
                        end else begin
                            huns_d  = 4'd0;
                            thous_d = thous_q + 4'd1;
                        end
                    end
                end
            end
            pending_d = pending_d + pts_add;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            serve_q   <= '0;
            alive_q   <= '1;
            lives_q   <= 4'(LIVES_INIT);
            launch_q  <= 1'b1;
            pending_q <= '0;
            thous_q   <= 4'd0;
            huns_q    <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            serve_q   <= serve_d;
            alive_q   <= alive_d;
            lives_q   <= lives_d;
            launch_q  <= launch;
            pending_q <= pending_d;
            thous_q   <= thous_d;
            huns_q    <= huns_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
        end
    end

    assign state       = state_q;
    assign ball_park   = (state_q == StIdle) || (state_q == StServe) ||
                         (state_q == StOver) || (state_q == StWon);
    assign ball_run    = (state_q == StPlay);
    assign brick_alive = alive_q;
    assign lives       = lives_q;
    assign thous       = thous_q;
    assign huns        = huns_q;
    assign tens        = tens_q;
    assign ones        = ones_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios plus random play against a
// behavioural game model, and a wide instance that drives the score into saturation.
module tb_game_sequencer;
    localparam int SatBricks = 700;

    logic       clk = 1'b0;
    logic       rst, frame_tick, launch, pause, ball_lost;
    logic [5:0] brick_hit;
    logic [2:0] state;
    logic       ball_park, ball_run;
    logic [5:0] brick_alive;
    logic [3:0] lives, thous, huns, tens, ones;

    logic                 rst_s, launch_s, ft_s;
    logic [SatBricks-1:0] hit_s, alive_s;
    logic [2:0]           state_s;
    logic                 park_s, run_s;
    logic [3:0]           lives_s, thous_s, huns_s, tens_s, ones_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: score and pending as plain integers.
    int         m_state, m_lives, m_score, m_pend, m_cnt;
    logic [5:0] m_alive;
    bit         m_lq;

    always #5 clk = ~clk;

    game_sequencer u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch), .pause(pause),
        .brick_hit(brick_hit), .ball_lost(ball_lost), .state(state), .ball_park(ball_park),
        .ball_run(ball_run), .brick_alive(brick_alive), .lives(lives), .thous(thous),
        .huns(huns), .tens(tens), .ones(ones)
    );

    game_sequencer #(
        .NUM_BRICKS(SatBricks), .LIVES_INIT(3), .BRICK_POINTS(15), .SERVE_FRAMES(1)
    ) u_sat (
        .clk(clk), .rst(rst_s), .frame_tick(ft_s), .launch(launch_s), .pause(1'b0),
        .brick_hit(hit_s), .ball_lost(1'b0), .state(state_s), .ball_park(park_s),
        .ball_run(run_s), .brick_alive(alive_s), .lives(lives_s), .thous(thous_s),
        .huns(huns_s), .tens(tens_s), .ones(ones_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_alive = '1; m_lives = 3; m_score = 0; m_pend = 0; m_cnt = 0; m_lq = 1'b1;
    endtask

    task automatic model_step();
        bit         rise;
        logic [5:0] newly;
        rise = launch && !m_lq;
        m_lq = launch;
        if (m_pend > 0) begin
            if (m_score == 9999) m_pend = 0;
            else begin m_score++; m_pend--; end
        end
        case (m_state)
            0: if (rise) begin m_state = 1; m_cnt = 60; end
            1: if (frame_tick && !pause) begin
                if (m_cnt == 1) m_state = 2;
                else m_cnt--;
            end
            2: if (pause) m_state = 3;
            else begin
                newly   = brick_hit & m_alive;
                m_alive = m_alive & ~brick_hit;
                m_pend  = m_pend + $countones(newly);
                if (m_alive == 0) m_state = 5;
                else if (ball_lost) begin
                    m_lives--;
                    if (m_lives == 0) m_state = 4;
                    else begin m_state = 1; m_cnt = 60; end
                end
            end
            3: if (!pause) m_state = 2;
            default: if (rise) begin
                m_state = 0; m_alive = '1; m_lives = 3; m_score = 0; m_pend = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("ball_park", 32'(ball_park), 32'(m_state == 0 || m_state == 1 ||
                                               m_state == 4 || m_state == 5));
        check("ball_run", 32'(ball_run), 32'(m_state == 2));
        check("alive", 32'(brick_alive), 32'(m_alive));
        check("lives", 32'(lives), 32'(m_lives));
        check("score", 32'({thous, huns, tens, ones}), 32'(to_bcd(m_score)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic start_play();
        launch = 1'b1; cycle(); launch = 1'b0;
        frame_tick = 1'b1; cycles(60); frame_tick = 1'b0;
    endtask

    task automatic sat_play_all();
        @(negedge clk) launch_s = 1'b1;
        @(negedge clk) launch_s = 1'b0; ft_s = 1'b1;
        @(negedge clk) ft_s = 1'b0; hit_s = '1;
        @(negedge clk) hit_s = '0;
    endtask

    initial begin
        rst = 1'b1; launch = 1'b1; pause = 1'b0; frame_tick = 1'b0;
        brick_hit = '0; ball_lost = 1'b0;
        rst_s = 1'b1; launch_s = 1'b0; ft_s = 1'b0; hit_s = '0;
        model_reset();
        #3;
        compare_all();
        @(negedge clk) rst = 1'b0;

        // Launch held across reset must not start a game.
        cycles(3);
        launch = 1'b0; cycle();
        launch = 1'b1; cycle();
        check("serve_after_rise", 32'(state), 32'd1);
        launch = 1'b0;
        frame_tick = 1'b1; cycles(59);
        check("still_serve_59", 32'(state), 32'd1);
        cycle();
        check("play_after_60", 32'(state), 32'd2);
        check("park_low_in_play", 32'(ball_park), 32'd0);
        frame_tick = 1'b0;

        brick_hit = 6'b000101; cycle(); brick_hit = '0;
        check("alive_after_hit", 32'(brick_alive), 32'h3a);
        cycles(2);
        check("score_two", 32'({thous, huns, tens, ones}), 32'h0002);
        brick_hit = 6'b000001; cycle(); brick_hit = '0;
        cycles(3);
        check("dead_hit_no_score", 32'({thous, huns, tens, ones}), 32'h0002);

        pause = 1'b1; cycle();
        check("paused", 32'(state), 32'd3);
        brick_hit = 6'b000010; ball_lost = 1'b1; cycle(); brick_hit = '0; ball_lost = 1'b0;
        check("paused_alive", 32'(brick_alive), 32'h3a);
        pause = 1'b0; cycle();

        // Lose a life, then freeze the serve countdown midway with pause.
        ball_lost = 1'b1; cycle(); ball_lost = 1'b0;
        check("lives_two", 32'(lives), 32'd2);
        frame_tick = 1'b1; cycles(30);
        pause = 1'b1; cycles(10);
        pause = 1'b0; cycles(29);
        check("serve_frozen", 32'(state), 32'd1);
        cycle();
        check("play_after_freeze", 32'(state), 32'd2);
        frame_tick = 1'b0;
        ball_lost = 1'b1; cycle(); ball_lost = 1'b0;
        frame_tick = 1'b1; cycles(60); frame_tick = 1'b0;
        ball_lost = 1'b1; cycle(); ball_lost = 1'b0;
        check("over", 32'(state), 32'd4);
        check("lives_zero", 32'(lives), 32'd0);
        launch = 1'b1; cycle(); launch = 1'b0;
        check("new_game_state", 32'(state), 32'd0);
        check("new_game_lives", 32'(lives), 32'd3);
        check("new_game_score", 32'({thous, huns, tens, ones}), 32'h0000);
        check("new_game_alive", 32'(brick_alive), 32'h3f);

        // Last brick together with ball loss wins without losing a life.
        cycle();
        start_play();
        brick_hit = 6'b111110; cycle();
        brick_hit = 6'b000001; ball_lost = 1'b1; cycle();
        brick_hit = '0; ball_lost = 1'b0;
        check("won", 32'(state), 32'd5);
        check("won_lives", 32'(lives), 32'd3);
        cycles(8);
        check("won_score", 32'({thous, huns, tens, ones}), 32'h0006);

        // Random play against the model, with an occasional asynchronous reset.
        for (int i = 0; i < 4000; i++) begin
            launch     = ($urandom_range(0, 7) == 0);
            frame_tick = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 63) == 0) pause = !pause;
            brick_hit  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'b0;
            ball_lost  = ($urandom_range(0, 49) == 0);
            if (i % 1000 == 999) begin
                rst = 1'b1; #2;
                model_reset();
                compare_all();
                rst = 1'b0;
            end
            cycle();
        end

        // Wide instance: 700 bricks x 15 points overflows 9999.
        @(negedge clk) rst_s = 1'b0;
        sat_play_all();
        check("sat_won", 32'(state_s), 32'd5);
        repeat (5000) @(negedge clk);
        check("sat_mid", 32'({thous_s, huns_s, tens_s, ones_s}), 32'h5000);
        repeat (6000) @(negedge clk);
        check("sat_max", 32'({thous_s, huns_s, tens_s, ones_s}), 32'h9999);
        repeat (100) @(negedge clk);
        check("sat_hold", 32'({thous_s, huns_s, tens_s, ones_s}), 32'h9999);
        @(negedge clk) launch_s = 1'b1;
        @(negedge clk) launch_s = 1'b0;
        check("sat_new_game", 32'({thous_s, huns_s, tens_s, ones_s}), 32'h0000);
        sat_play_all();
        repeat (3000) @(negedge clk);
        check("sat_drain", 32'({thous_s, huns_s, tens_s, ones_s}), 32'h3000);
        rst_s = 1'b1; #1;
        check("sat_rst_score", 32'({thous_s, huns_s, tens_s, ones_s}), 32'h0000);
        check("sat_rst_state", 32'(state_s), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
